// File: rtl/game_pkg.sv
// Shared types and constants for the block-stacking game session controller.
package game_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_COUNT = 3'd1,
    S_PLAY  = 3'd2,
    S_PAUSE = 3'd3,
    S_OVER  = 3'd4
  } session_state_e;

  localparam logic [7:0] KEY_UP    = 8'h75;
  localparam logic [7:0] KEY_DOWN  = 8'h72;
  localparam logic [7:0] KEY_ENTER = 8'h5a;
  localparam logic [7:0] KEY_ESC   = 8'h76;
  localparam logic [7:0] KEY_PAUSE = 8'h4d;

  localparam logic [23:0] MENU_SEL   = 24'hFFFF14;
  localparam logic [23:0] MENU_UNSEL = 24'h1414FF;
  localparam logic [23:0] BORDER     = 24'h323232;

  localparam int unsigned MENU_Y0    = 120;
  localparam int unsigned MENU_PITCH = 40;
  localparam int unsigned MENU_H     = 32;
  localparam int unsigned MENU_X0    = 240;
  localparam int unsigned MENU_X1    = 400;

  // Halve each 8-bit channel independently.
  function automatic logic [23:0] dim_rgb(input logic [23:0] c);
    return {1'b0, c[23:17], 1'b0, c[15:9], 1'b0, c[7:1]};
  endfunction

endpackage

// File: rtl/key_edge_det.sv
// Per-player scan-code history; flags a new nonzero code as a single press event.
module key_edge_det (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] key,
  output logic       press
);

  logic [7:0] hist_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) hist_q <= '0;
    else          hist_q <= key;
  end

  assign press = (key != hist_q) && (key != 8'h00);

endmodule

// File: rtl/game_session_ctrl.sv
// Session controller: menu, countdown, pause and winner handling for up to four
// side-by-side game fields, plus the VGA pixel mux.
module game_session_ctrl
  import game_pkg::*;
#(
  parameter int unsigned NUM_PLAYERS = 2,
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned FIELD_W     = 160,
  parameter int unsigned COUNT_CYC   = 150000000
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [9:0]                x,
  input  logic [9:0]                y,
  input  logic [8*NUM_PLAYERS-1:0]  i_key,
  input  logic [NUM_PLAYERS-1:0]    i_game_over,
  input  logic [24*NUM_PLAYERS-1:0] i_game_rgb,
  output logic [10*NUM_PLAYERS-1:0] o_x_local,
  output logic [NUM_PLAYERS-1:0]    o_start,
  output logic                      o_pause,
  output logic [2:0]                o_state,
  output logic [2:0]                o_num_sel,
  output logic [1:0]                o_winner,
  output logic                      o_winner_vld,
  output logic [7:0]                o_vga_r,
  output logic [7:0]                o_vga_g,
  output logic [7:0]                o_vga_b
);

  localparam logic [9:0]  FieldW    = 10'(FIELD_W);
  localparam logic [31:0] CountLast = 32'(COUNT_CYC - 1);

  session_state_e         state_q, state_d;
  logic [2:0]             num_sel_q, num_sel_d;
  logic [2:0]             n_q, n_d;
  logic [9:0]             off_q [NUM_PLAYERS];
  logic [9:0]             off_d [NUM_PLAYERS];
  logic [9:0]             off_new [NUM_PLAYERS];
  logic [31:0]            cnt_q, cnt_d;
  logic [NUM_PLAYERS-1:0] start_q, start_d;
  logic                   pause_q;
  logic [1:0]             winner_q, winner_d;
  logic                   winner_vld_q, winner_vld_d;

  logic [NUM_PLAYERS-1:0] press;
  logic [9:0]             x_rel [NUM_PLAYERS];
  logic                   unused_press;
  logic                   k_up, k_down, k_enter, k_esc, k_pause;
  logic [2:0]             alive_cnt;
  logic [1:0]             alive_idx;
  logic                   end_cond;
  logic [23:0]            rgb;

  for (genvar k = 0; k < NUM_PLAYERS; k++) begin : g_lane
    key_edge_det u_key_edge_det (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .key    (i_key[8*k +: 8]),
      .press  (press[k])
    );
    assign x_rel[k]               = x - off_q[k];
    assign o_x_local[10*k +: 10] = (3'(k) < n_q) ? x_rel[k] : '0;
  end

  // Only player 0 drives session control; other players' events go to their games.
  assign unused_press = ^press;
  assign k_up    = press[0] && (i_key[7:0] == KEY_UP);
  assign k_down  = press[0] && (i_key[7:0] == KEY_DOWN);
  assign k_enter = press[0] && (i_key[7:0] == KEY_ENTER);
  assign k_esc   = press[0] && (i_key[7:0] == KEY_ESC);
  assign k_pause = press[0] && (i_key[7:0] == KEY_PAUSE);

  // Field placement for the pending selection, built by accumulation.
  always_comb begin
    logic [9:0] span;
    logic [9:0] acc;
    span = '0;
    for (int k = 0; k < NUM_PLAYERS; k++) begin
      if (3'(k) < num_sel_q) span = span + FieldW;
    end
    acc = (10'(H_ACTIVE) - span) >> 1;
    for (int k = 0; k < NUM_PLAYERS; k++) begin
      off_new[k] = acc;
      acc        = acc + FieldW;
    end
  end

  always_comb begin
    alive_cnt = '0;
    alive_idx = '0;
    for (int k = 0; k < NUM_PLAYERS; k++) begin
      if ((3'(k) < n_q) && !i_game_over[k]) begin
        alive_cnt = alive_cnt + 3'd1;
        alive_idx = 2'(k);
      end
    end
    end_cond = (n_q == 3'd1) ? i_game_over[0] : (alive_cnt <= 3'd1);
  end

  always_comb begin
    state_d      = state_q;
    num_sel_d    = num_sel_q;
    n_d          = n_q;
    off_d        = off_q;
    cnt_d        = cnt_q;
    start_d      = '0;
    winner_d     = winner_q;
    winner_vld_d = winner_vld_q;
    unique case (state_q)
      S_IDLE: begin
        if (k_down && (num_sel_q < 3'(NUM_PLAYERS))) num_sel_d = num_sel_q + 3'd1;
        else if (k_up && (num_sel_q > 3'd1))         num_sel_d = num_sel_q - 3'd1;
        if (k_enter) begin
          n_d     = num_sel_q;
          off_d   = off_new;
          cnt_d   = CountLast;
          state_d = S_COUNT;
        end
      end
      S_COUNT: begin
        if (k_esc) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          state_d = S_PLAY;
          for (int k = 0; k < NUM_PLAYERS; k++) start_d[k] = (3'(k) < n_q);
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      S_PLAY: begin
        if (k_esc) begin
          state_d = S_IDLE;
        end else if (k_pause) begin
          state_d = S_PAUSE;
        end else if (end_cond) begin
          state_d      = S_OVER;
          winner_vld_d = (alive_cnt == 3'd1);
          if (alive_cnt == 3'd1) winner_d = alive_idx;
        end
      end
      S_PAUSE: begin
        if (k_esc)        state_d = S_IDLE;
        else if (k_pause) state_d = S_PLAY;
      end
      S_OVER: begin
        if (k_enter || k_esc) begin
          state_d      = S_IDLE;
          winner_vld_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      num_sel_q    <= 3'd1;
      n_q          <= '0;
      cnt_q        <= '0;
      start_q      <= '0;
      pause_q      <= 1'b0;
      winner_q     <= '0;
      winner_vld_q <= 1'b0;
      for (int k = 0; k < NUM_PLAYERS; k++) off_q[k] <= '0;
    end else begin
      state_q      <= state_d;
      num_sel_q    <= num_sel_d;
      n_q          <= n_d;
      cnt_q        <= cnt_d;
      start_q      <= start_d;
      pause_q      <= (state_d == S_PAUSE);
      winner_q     <= winner_d;
      winner_vld_q <= winner_vld_d;
      off_q        <= off_d;
    end
  end

  always_comb begin
    rgb = '0;
    if (state_q == S_IDLE) begin
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        if ((y >= 10'(MENU_Y0 + MENU_PITCH * i)) && (y < 10'(MENU_Y0 + MENU_PITCH * i + MENU_H)) &&
            (x >= 10'(MENU_X0)) && (x < 10'(MENU_X1))) begin
          rgb = (3'(i) == (num_sel_q - 3'd1)) ? MENU_SEL : MENU_UNSEL;
        end
      end
    end else begin
      rgb = BORDER;
      for (int k = 0; k < NUM_PLAYERS; k++) begin
        if ((3'(k) < n_q) && (x_rel[k] < FieldW)) begin
          rgb = i_game_rgb[24*k +: 24];
          if ((state_q == S_OVER) && !(winner_vld_q && (winner_q == 2'(k)))) rgb = dim_rgb(rgb);
        end
      end
      if (state_q == S_PAUSE) rgb = dim_rgb(rgb);
    end
  end

  assign {o_vga_r, o_vga_g, o_vga_b} = rgb;
  assign o_state      = state_q;
  assign o_num_sel    = num_sel_q;
  assign o_start      = start_q;
  assign o_pause      = pause_q;
  assign o_winner     = winner_q;
  assign o_winner_vld = winner_vld_q;

endmodule

// File: tb/tb_game_session_ctrl.sv
// Randomised bench for game_session_ctrl against a behavioural session model.
module tb_game_session_ctrl;

  localparam int NP = 2;
  localparam int FW = 160;
  localparam int HA = 640;
  localparam int CC = 10;

  localparam logic [7:0] UP = 8'h75, DOWN = 8'h72, ENTER = 8'h5a, ESC = 8'h76, PAUSE = 8'h4d;

  logic            clk;
  logic            rst_n;
  logic [9:0]      x, y;
  logic [8*NP-1:0] key;
  logic [NP-1:0]   game_over;
  logic [24*NP-1:0] game_rgb;
  logic [10*NP-1:0] x_local;
  logic [NP-1:0]   start;
  logic            pause;
  logic [2:0]      state, num_sel;
  logic [1:0]      winner;
  logic            winner_vld;
  logic [7:0]      vga_r, vga_g, vga_b;

  game_session_ctrl #(
    .NUM_PLAYERS(NP),
    .H_ACTIVE   (HA),
    .FIELD_W    (FW),
    .COUNT_CYC  (CC)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .x           (x),
    .y           (y),
    .i_key       (key),
    .i_game_over (game_over),
    .i_game_rgb  (game_rgb),
    .o_x_local   (x_local),
    .o_start     (start),
    .o_pause     (pause),
    .o_state     (state),
    .o_num_sel   (num_sel),
    .o_winner    (winner),
    .o_winner_vld(winner_vld),
    .o_vga_r     (vga_r),
    .o_vga_g     (vga_g),
    .o_vga_b     (vga_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model of the session.
  int         m_state, m_sel, m_n, m_L, m_cnt, m_win;
  logic       m_vld, m_pause;
  logic [1:0] m_start;
  logic [7:0] m_prev;

  always @(posedge clk) begin
    logic [7:0] k0;
    logic       ev;
    int         alive, idx;
    logic       fin;
    k0 = key[7:0];
    if (!rst_n) begin
      m_state = 0; m_sel = 1; m_n = 0; m_L = 0; m_cnt = 0; m_win = 0;
      m_vld = 0; m_pause = 0; m_start = 0; m_prev = 0;
    end else begin
      ev = (k0 != m_prev) && (k0 != 0);
      m_start = 0;
      case (m_state)
        0: begin
          if (ev && k0 == ENTER) begin
            m_n = m_sel; m_L = (HA - m_n * FW) / 2; m_cnt = CC - 1; m_state = 1;
          end
          if (ev && k0 == DOWN && m_sel < NP) m_sel++;
          if (ev && k0 == UP && m_sel > 1) m_sel--;
        end
        1: begin
          if (ev && k0 == ESC) m_state = 0;
          else if (m_cnt == 0) begin m_state = 2; m_start = 2'((1 << m_n) - 1); end
          else m_cnt--;
        end
        2: begin
          alive = 0; idx = 0;
          for (int k = 0; k < m_n; k++) if (!game_over[k]) begin alive++; idx = k; end
          fin = (m_n == 1) ? game_over[0] : (alive <= 1);
          if (ev && k0 == ESC) m_state = 0;
          else if (ev && k0 == PAUSE) m_state = 3;
          else if (fin) begin
            m_state = 4;
            m_vld = (alive == 1);
            if (alive == 1) m_win = idx;
          end
        end
        3: begin
          if (ev && k0 == ESC) m_state = 0;
          else if (ev && k0 == PAUSE) m_state = 2;
        end
        default: begin
          if (ev && (k0 == ENTER || k0 == ESC)) begin m_state = 0; m_vld = 0; end
        end
      endcase
      m_pause = (m_state == 3);
      m_prev = k0;
    end
  end

  function automatic logic [23:0] half(input logic [23:0] c);
    logic [7:0] r, g, b;
    r = c[23:16] / 2; g = c[15:8] / 2; b = c[7:0] / 2;
    return {r, g, b};
  endfunction

  function automatic logic [23:0] exp_rgb();
    int xi, yi, lo;
    logic [23:0] c;
    xi = int'(x); yi = int'(y);
    if (m_state == 0) begin
      for (int i = 0; i < NP; i++)
        if (yi >= 120 + 40 * i && yi < 152 + 40 * i && xi >= 240 && xi < 400)
          return (i == m_sel - 1) ? 24'hFFFF14 : 24'h1414FF;
      return 24'h0;
    end
    c = 24'h323232;
    for (int k = 0; k < m_n; k++) begin
      lo = m_L + k * FW;
      if (xi >= lo && xi < lo + FW) begin
        c = game_rgb[24*k +: 24];
        if (m_state == 4 && !(m_vld && m_win == k)) c = half(c);
      end
    end
    if (m_state == 3) c = half(c);
    return c;
  endfunction

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    int e;
    chk("state", 32'(state), 32'(m_state));
    chk("num_sel", 32'(num_sel), 32'(m_sel));
    chk("pause", 32'(pause), 32'(m_pause));
    chk("start", 32'(start), 32'(m_start));
    chk("winner_vld", 32'(winner_vld), 32'(m_vld));
    if (m_vld) chk("winner", 32'(winner), 32'(m_win));
    chk("vga", 32'({vga_r, vga_g, vga_b}), 32'(exp_rgb()));
    if (m_state != 0) begin
      for (int k = 0; k < NP; k++) begin
        e = (k < m_n) ? ((int'(x) - m_L - k * FW) & 1023) : 0;
        chk("x_local", 32'(x_local[10*k +: 10]), 32'(e));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic press(input logic [7:0] code);
    key[7:0] = code;
    cyc(1);
    key[7:0] = 8'h00;
    cyc(1);
  endtask

  task automatic start_game(output int ncount, output logic [1:0] st);
    key[7:0] = ENTER;
    cyc(1);
    key[7:0] = 8'h00;
    #1;
    ncount = 0;
    while (state == 3'd1 && ncount < 40) begin
      ncount++;
      cyc(1);
      #1;
    end
    st = start;
  endtask

  initial begin
    int nc;
    logic [1:0] st;
    rst_n = 1'b0; x = 10'd330; y = 10'd100; key = '0; game_over = '0; game_rgb = '0;
    cyc(2);
    rst_n = 1'b1;
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_sel", 32'(num_sel), 32'd1);
    chk("rst_winner", 32'(winner), 32'd0);
    x = 10'd300; y = 10'd130; #1;
    chk("menu_bar0_sel", 32'({vga_r, vga_g, vga_b}), 32'h00FFFF14);
    y = 10'd170; #1;
    chk("menu_bar1_unsel", 32'({vga_r, vga_g, vga_b}), 32'h001414FF);

    repeat (5) press(DOWN);
    chk("sel_sat", 32'(num_sel), 32'd2);
    press(UP);
    key[7:0] = DOWN;
    cyc(100);
    key[7:0] = 8'h00;
    #1;
    chk("sel_hold", 32'(num_sel), 32'd2);

    x = 10'd330; y = 10'd100;
    game_rgb = {24'hC86428, 24'h804020};
    start_game(nc, st);
    chk("count_len", 32'(nc), 32'd10);
    chk("play_state", 32'(state), 32'd2);
    chk("start_pulse", 32'(st), 32'h3);
    chk("xlocal1_330", 32'(x_local[19:10]), 32'd10);
    cyc(1); #1;
    chk("start_one_cycle", 32'(start), 32'h0);

    press(PAUSE);
    chk("paused", 32'(pause), 32'd1);
    chk("pause_state", 32'(state), 32'd3);
    chk("pause_dim", 32'({vga_r, vga_g, vga_b}), 32'h00643214);
    press(PAUSE);
    chk("unpaused", 32'(pause), 32'd0);

    game_over = 2'b01;
    cyc(1); #1;
    chk("over_state", 32'(state), 32'd4);
    chk("over_winner", 32'(winner), 32'd1);
    chk("over_vld", 32'(winner_vld), 32'd1);
    chk("winner_field", 32'({vga_r, vga_g, vga_b}), 32'h00C86428);
    x = 10'd170; #1;
    chk("loser_field", 32'({vga_r, vga_g, vga_b}), 32'h00402010);
    game_over = 2'b00;
    press(ENTER);

    start_game(nc, st);
    cyc(3);
    game_over = 2'b11;
    cyc(1); #1;
    chk("tie_state", 32'(state), 32'd4);
    chk("tie_vld", 32'(winner_vld), 32'd0);
    game_over = 2'b00;
    press(ENTER);

    key[7:0] = ENTER;
    cyc(1);
    key[7:0] = 8'h00;
    cyc(6);
    key[7:0] = ESC;
    cyc(1); #1;
    chk("esc_idle", 32'(state), 32'd0);
    chk("esc_nostart", 32'(start), 32'd0);
    key[7:0] = 8'h00;
    cyc(1);

    start_game(nc, st);
    cyc(2);
    rst_n = 1'b0;
    cyc(1); #1;
    chk("mid_rst_state", 32'(state), 32'd0);
    chk("mid_rst_sel", 32'(num_sel), 32'd1);
    chk("mid_rst_pause", 32'(pause), 32'd0);
    chk("mid_rst_vld", 32'(winner_vld), 32'd0);
    chk("mid_rst_xlocal", 32'(x_local), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 1500; i++) begin
      int sel, hold;
      sel = $urandom_range(0, 15);
      case (sel)
        0, 1, 2, 3: key[7:0] = 8'h00;
        4:          key[7:0] = UP;
        5:          key[7:0] = DOWN;
        6, 7:       key[7:0] = ENTER;
        8:          key[7:0] = ESC;
        9, 10:      key[7:0] = PAUSE;
        default:    key[7:0] = 8'($urandom);
      endcase
      key[15:8] = 8'($urandom_range(0, 3) == 0 ? $urandom : 0);
      hold = $urandom_range(1, 6);
      for (int h = 0; h < hold; h++) begin
        x = 10'($urandom_range(0, 639));
        y = 10'($urandom_range(0, 479));
        game_rgb = {24'($urandom), 24'($urandom)};
        if ($urandom_range(0, 29) == 0) game_over[$urandom_range(0, 1)] = 1'b1;
        if ($urandom_range(0, 39) == 0) game_over = 2'b00;
        cyc(1);
      end
    end

    cyc(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
